decode_ctrl_stage: RTL
======================

Name: decode_ctrl_stage

Overview:
- Registered successor to the combinational main control decoder; sits between IF/ID and ID/EX.
- Decodes a MIPS instruction into the EX control bundle.
- Inserts bubbles for load-use hazards and honours flush.
- Sequences a multi-cycle mult/div unit and interlocks mfhi/mflo against it.

Parameters:
ALU_CTRL_W, 4, alu_control width (>=4; codes zero-extended)
REG_ADDR_W, 5, register specifier width
MULDIV_CYCLES, 8, busy cycles after a mult/div issue (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  instruction present from IF/ID
in_ready  out  1  instruction accepted this cycle (combinational)
instruction  in  32  MIPS word
flush  in  1  kill instruction entering ID/EX this edge
ex_mem_read  in  1  instruction now in EX is a load
ex_rt  in  REG_ADDR_W  destination of that load
out_valid  out  1  registered bundle is a real instruction
reg_write, mem_to_reg_write, mem_read, mem_write, branch, branch_ne, alu_source, alu_source_shift, reg_dst  out  1 each  registered controls
alu_control  out  ALU_CTRL_W  registered ALU op
dst_reg  out  REG_ADDR_W  rd if reg_dst else rt; 0 for bubbles
muldiv_start  out  1  one-cycle issue pulse, registered
muldiv_unsigned  out  1  valid with muldiv_start
muldiv_busy  out  1  FSM in BUSY

Behaviour:
- Reset: all registered outputs 0, FSM IDLE, counter 0.
- ALU codes: add 1, sub 2, and 3, or 4, xor 5, nor 6, slt 7, sll 8, srl 9, sra A, mult B, div C, mfhi D, mflo E, lui F.
- R-type (op 0): add/addu/sub/subu/and/or/xor/nor/slt/sll/sllv/srl/srlv/sra/srav. reg_write=1, reg_dst=1. alu_source_shift=1 only for funct 0, 2, 3.
- mfhi (0x10) / mflo (0x12): reg_write=1, reg_dst=1.
- mult/multu/div/divu (0x18–0x1B): reg_write=0, muldiv_start=1. muldiv_unsigned=1 for 0x19 and 0x1B.
- jr (0x08): no write; all controls 0, out_valid=1.
- I-type: addi/addiu (add), slti (slt), andi, ori, xori, lui all set alu_source=1, reg_write=1, reg_dst=0.
- lw: additionally mem_read=1 and mem_to_reg_write=1.
- sw: mem_write=1, alu_source=1, add.
- beq/bne: branch=1, alu_control=sub. bne also sets branch_ne=1.
- Unlisted opcodes/functs decode as a bubble with out_valid=1.
- Bubble: every control output 0, dst_reg=0.
- Rule for don't-care fields: always drive 0, never hold previous values.
- Hazard:
  - haz = in_valid & ex_mem_read & ex_rt!=0 & (rs_hit | rt_hit).
  - rs_hit = (ex_rt==rs) & !alu_source_shift.
  - rt_hit = (ex_rt==rt) for R-type, beq, bne, sw.
- Mult/div interlock: md_stall = in_valid & (FSM==BUSY) & instruction is mfhi/mflo/mult/div class.
- in_ready = !reset & !haz & !md_stall.
- Each edge, priority order:
  1. reset
  2. flush → bubble, out_valid=0
  3. in_valid & in_ready → decoded bundle, out_valid=1
  4. otherwise → bubble, out_valid=0
- Latency: 1 cycle from acceptance to bundle.
- FSM IDLE→BUSY on the edge that registers muldiv_start=1; counter loads MULDIV_CYCLES.
- In BUSY, counter decrements each edge; BUSY→IDLE on the edge where counter==1.
- muldiv_busy is high for exactly MULDIV_CYCLES cycles after the issue cycle.
- A flush on the issuing edge wins: no start, no BUSY.
- Flush during BUSY does not cancel the count.
- reset mid-BUSY returns to IDLE immediately.
- flush and haz together: flush wins. in_ready still reflects the hazard.

Optional Feature:
DECODE_ILLEGAL_TRAP_EN
- Defined: extra output illegal (1b, registered) is set with out_valid=1 and bubble controls for any unlisted opcode/funct; cleared on reset, flush, or next bundle.
- Undefined: port absent; unlisted encodings are silent bubbles.

Test Plan:
- add $3,$1,$2 (0x00221820), in_valid=1 → next cycle reg_write=1, reg_dst=1, alu_control=1, dst_reg=3, out_valid=1.
- ex_mem_read=1, ex_rt=2, instruction sw $2,0($5) → in_ready=0, bubble, out_valid=0. Drop ex_mem_read → issues with mem_write=1, alu_source=1.
- mult $4,$5 then mflo $6, MULDIV_CYCLES=3 → muldiv_start pulse, muldiv_busy high 3 cycles, mflo stalls 3 cycles then issues alu_control=E, dst_reg=6.
- bne $1,$2 with flush=1 on same edge → out_valid=0, branch=0. Next bne without flush → branch=1, branch_ne=1, alu_control=2.
- sll $2,$3,4 while ex_rt=0 (any rs) and ex_mem_read=1 → no stall, alu_source_shift=1, alu_control=8.
- reset asserted mid-BUSY → next cycle muldiv_busy=0, all outputs 0. Opcode 0x3F → bubble, illegal=1 when DECODE_ILLEGAL_TRAP_EN is defined.

Source files
------------

// File: rtl/decode_ctrl_stage.sv
// -----------------------------------------------------------------------------
// decode_ctrl_stage
//
// Registered main-control decoder sitting between IF/ID and ID/EX. Decodes a
// MIPS word into the EX control bundle one cycle after acceptance. It inserts
// bubbles for load-use hazards and flushes. It also sequences a multi-cycle
// mult/div unit, holding mfhi/mflo/mult/div back while that unit is busy.
//
// Ports
//   clk               in   rising-edge clock
//   reset             in   synchronous, active-high
//   in_valid          in   instruction present from IF/ID
//   in_ready          out  instruction accepted this cycle (combinational)
//   instruction       in   32-bit MIPS word
//   flush             in   kill the instruction entering ID/EX on this edge
//   ex_mem_read       in   instruction now in EX is a load
//   ex_rt             in   destination register of that load
//   out_valid         out  registered bundle is a real instruction
//   reg_write .. reg_dst  out  registered single-bit controls
//   alu_control       out  registered ALU op (4-bit code, zero-extended)
//   dst_reg           out  rd if reg_dst else rt; 0 for bubbles
//   muldiv_start      out  one-cycle mult/div issue pulse
//   muldiv_unsigned   out  unsigned flag, valid with muldiv_start
//   muldiv_busy       out  mult/div unit is in its busy window
//   illegal           out  only with DECODE_ILLEGAL_TRAP_EN: the registered
//                          bundle came from an unlisted opcode/funct
//
// Build option: define DECODE_ILLEGAL_TRAP_EN to add the illegal output.
// -----------------------------------------------------------------------------
module decode_ctrl_stage #(
  parameter int ALU_CTRL_W    = 4,
  parameter int REG_ADDR_W    = 5,
  parameter int MULDIV_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic                  flush,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  out_valid,
  output logic                  reg_write,
  output logic                  mem_to_reg_write,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  branch,
  output logic                  branch_ne,
  output logic                  alu_source,
  output logic                  alu_source_shift,
  output logic                  reg_dst,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [REG_ADDR_W-1:0] dst_reg,
  output logic                  muldiv_start,
  output logic                  muldiv_unsigned,
  output logic                  muldiv_busy
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic                  illegal
`endif
);

  // ALU operation codes (4-bit, zero-extended onto alu_control).
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;
  localparam logic [3:0] ALU_AND  = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4;
  localparam logic [3:0] ALU_XOR  = 4'h5;
  localparam logic [3:0] ALU_NOR  = 4'h6;
  localparam logic [3:0] ALU_SLT  = 4'h7;
  localparam logic [3:0] ALU_SLL  = 4'h8;
  localparam logic [3:0] ALU_SRL  = 4'h9;
  localparam logic [3:0] ALU_SRA  = 4'hA;
  localparam logic [3:0] ALU_MULT = 4'hB;
  localparam logic [3:0] ALU_DIV  = 4'hC;
  localparam logic [3:0] ALU_MFHI = 4'hD;
  localparam logic [3:0] ALU_MFLO = 4'hE;
  localparam logic [3:0] ALU_LUI  = 4'hF;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam int CNT_W = (MULDIV_CYCLES < 2) ? 1 : $clog2(MULDIV_CYCLES + 1);

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       branch_ne;
    logic       alu_source;
    logic       alu_source_shift;
    logic       reg_dst;
    logic       muldiv_start;
    logic       muldiv_unsigned;
    logic [3:0] alu;
  } ctrl_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // Instruction fields.
  logic [5:0]            opcode;
  logic [5:0]            funct;
  logic [REG_ADDR_W-1:0] rs_f;
  logic [REG_ADDR_W-1:0] rt_f;
  logic [REG_ADDR_W-1:0] rd_f;
  logic                  unused_shamt;

  assign opcode       = instruction[31:26];
  assign funct        = instruction[5:0];
  assign rs_f         = REG_ADDR_W'(instruction[25:21]);
  assign rt_f         = REG_ADDR_W'(instruction[20:16]);
  assign rd_f         = REG_ADDR_W'(instruction[15:11]);
  assign unused_shamt = ^instruction[10:6];

  ctrl_t     dec;
  logic      dec_illegal;
  logic      md_class;   // mfhi/mflo/mult/multu/div/divu
  logic      rt_used;    // rt is a source: R-type, beq, bne, sw
  logic      haz;
  logic      md_stall;
  logic      issue;

  ctrl_t                 ctrl_q;
  logic                  out_valid_q;
  logic [REG_ADDR_W-1:0] dst_q;
  md_state_t             state_q;
  logic [CNT_W-1:0]      cnt_q;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    dec         = '0;
    dec_illegal = 1'b0;
    md_class    = 1'b0;
    rt_used     = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        rt_used       = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_dst   = 1'b1;
        case (funct)
          6'h00: begin dec.alu = ALU_SLL; dec.alu_source_shift = 1'b1; end
          6'h02: begin dec.alu = ALU_SRL; dec.alu_source_shift = 1'b1; end
          6'h03: begin dec.alu = ALU_SRA; dec.alu_source_shift = 1'b1; end
          6'h04: dec.alu = ALU_SLL;
          6'h06: dec.alu = ALU_SRL;
          6'h07: dec.alu = ALU_SRA;
          6'h08: dec = '0;  // jr: valid instruction, no controls
          6'h10: begin dec.alu = ALU_MFHI; md_class = 1'b1; end
          6'h12: begin dec.alu = ALU_MFLO; md_class = 1'b1; end
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            md_class            = 1'b1;
            dec.reg_write       = 1'b0;
            dec.reg_dst         = 1'b0;
            dec.muldiv_start    = 1'b1;
            dec.muldiv_unsigned = funct[0];  // multu / divu
            dec.alu             = funct[1] ? ALU_DIV : ALU_MULT;
          end
          6'h20, 6'h21: dec.alu = ALU_ADD;
          6'h22, 6'h23: dec.alu = ALU_SUB;
          6'h24: dec.alu = ALU_AND;
          6'h25: dec.alu = ALU_OR;
          6'h26: dec.alu = ALU_XOR;
          6'h27: dec.alu = ALU_NOR;
          6'h2A: dec.alu = ALU_SLT;
          default: begin
            dec         = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec.reg_write = 1'b1; dec.alu_source = 1'b1; dec.alu = ALU_ADD;
      end
      OP_SLTI: begin
        dec.reg_write = 1'b1; dec.alu_source = 1'b1; dec.alu = ALU_SLT;
      end
      OP_ANDI: begin
        dec.reg_write = 1'b1; dec.alu_source = 1'b1; dec.alu = ALU_AND;
      end
      OP_ORI: begin
        dec.reg_write = 1'b1; dec.alu_source = 1'b1; dec.alu = ALU_OR;
      end
      OP_XORI: begin
        dec.reg_write = 1'b1; dec.alu_source = 1'b1; dec.alu = ALU_XOR;
      end
      OP_LUI: begin
        dec.reg_write = 1'b1; dec.alu_source = 1'b1; dec.alu = ALU_LUI;
      end
      OP_LW: begin
        dec.reg_write        = 1'b1;
        dec.mem_read         = 1'b1;
        dec.mem_to_reg_write = 1'b1;
        dec.alu_source       = 1'b1;
        dec.alu              = ALU_ADD;
      end
      OP_SW: begin
        rt_used        = 1'b1;
        dec.mem_write  = 1'b1;
        dec.alu_source = 1'b1;
        dec.alu        = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        rt_used       = 1'b1;
        dec.branch    = 1'b1;
        dec.branch_ne = opcode[0];
        dec.alu       = ALU_SUB;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and handshake
  // ---------------------------------------------------------------------------
  // Shift-by-immediate forms carry no rs operand, so rs cannot collide.
  // A load to $0 never creates a dependency.
  assign haz = in_valid & ex_mem_read & (ex_rt != '0) &
               (((ex_rt == rs_f) & ~dec.alu_source_shift) |
                ((ex_rt == rt_f) & rt_used));

  assign md_stall = in_valid & (state_q == MD_BUSY) & md_class;
  assign in_ready = ~reset & ~haz & ~md_stall;

  // Flush outranks acceptance: the handshake still completes (in_ready is
  // unaffected) but nothing reaches ID/EX.
  assign issue = in_valid & in_ready & ~flush;

  // ---------------------------------------------------------------------------
  // ID/EX control bundle
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      dst_q       <= '0;
    end else if (issue) begin
      ctrl_q      <= dec;
      out_valid_q <= 1'b1;
      dst_q       <= dec_illegal ? '0 : (dec.reg_dst ? rd_f : rt_f);
    end else begin
      ctrl_q      <= '0;
      out_valid_q <= 1'b0;
      dst_q       <= '0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= issue & dec_illegal;
    end
  end

  assign illegal = illegal_q;
`endif

  // ---------------------------------------------------------------------------
  // Mult/div sequencer: BUSY for exactly MULDIV_CYCLES cycles after issue.
  // A mult/div cannot issue while BUSY because md_stall blocks it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (issue & dec.muldiv_start) begin
            state_q <= MD_BUSY;
            cnt_q   <= CNT_W'(MULDIV_CYCLES);
          end
        end
        MD_BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out_valid        = out_valid_q;
  assign reg_write        = ctrl_q.reg_write;
  assign mem_to_reg_write = ctrl_q.mem_to_reg_write;
  assign mem_read         = ctrl_q.mem_read;
  assign mem_write        = ctrl_q.mem_write;
  assign branch           = ctrl_q.branch;
  assign branch_ne        = ctrl_q.branch_ne;
  assign alu_source       = ctrl_q.alu_source;
  assign alu_source_shift = ctrl_q.alu_source_shift;
  assign reg_dst          = ctrl_q.reg_dst;
  assign alu_control      = ALU_CTRL_W'(ctrl_q.alu);
  assign dst_reg          = dst_q;
  assign muldiv_start     = ctrl_q.muldiv_start;
  assign muldiv_unsigned  = ctrl_q.muldiv_unsigned;
  assign muldiv_busy      = (state_q == MD_BUSY);

endmodule
